// File: rtl/mac_vector_feeder.sv
// Ping-pong operand feeder for an SB_MAC16 used as an unsigned 16x16 MAC.
// A producer fills one bank while the other streams one (A,B) pair per cycle.
// The block sequences clear, accumulate, drain and result-strobe phases so
// the dot product sits on the MAC O output when RESULT_STROBE pulses.
module mac_vector_feeder #(
    parameter int DEPTH      = 16,
    parameter int LEN_W      = 5,
    parameter int PIPE_DEPTH = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             WR_VALID,
    output logic             WR_READY,
    input  logic [15:0]      WR_A,
    input  logic [15:0]      WR_B,
    input  logic             WR_LAST,
    output logic [15:0]      MAC_A,
    output logic [15:0]      MAC_B,
    output logic             MAC_CE,
    output logic             MAC_OLOAD,
    output logic             RESULT_STROBE,
    output logic [LEN_W-1:0] RESULT_LEN,
    output logic             BUSY
);

    localparam int               IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DEPTH - 1);
    localparam logic [1:0]       DRAIN_LAST = 2'((PIPE_DEPTH > 0) ? PIPE_DEPTH - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    // Pair storage: entry {bank, index} holds {A, B}.
    logic [31:0]      r_mem [2*DEPTH];

    // Write side.
    logic             r_fill_bank;
    logic [IDX_W-1:0] r_wr_idx;
    logic [1:0]       r_full;
    logic [LEN_W-1:0] r_len [2];

    // Read side.
    logic             r_rd_bank;
    state_t           r_state;
    state_t           w_next_state;
    logic [IDX_W-1:0] r_rd_idx;
    logic [IDX_W-1:0] w_next_rd_idx;
    logic [1:0]       r_drain_cnt;
    logic [1:0]       w_next_drain_cnt;
    logic [LEN_W-1:0] r_cur_len;

    logic             w_accept;
    logic             w_commit;
    logic             w_release;
    logic             w_start;
    logic             w_last_pair;
    logic             w_ce;
    logic             w_oload;
    logic             w_strobe;
    logic             w_stream;
    logic [31:0]      w_rd_word;

    assign WR_READY    = ~r_full[r_fill_bank];
    assign w_accept    = WR_VALID & WR_READY;
    assign w_commit    = w_accept & (WR_LAST | (r_wr_idx == IDX_LAST));
    assign w_last_pair = (LEN_W'(r_rd_idx) + LEN_W'(1)) == r_cur_len;
    assign w_rd_word   = r_mem[{r_rd_bank, w_next_rd_idx}];
    assign BUSY        = (r_state != S_IDLE);

    // Store each accepted pair into the bank currently being filled.
    // NOTE: the pair memory has no reset; stale contents are never read
    // because a bank is only streamed after it has been written and committed.
    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_mem[{r_fill_bank, r_wr_idx}] <= {WR_A, WR_B};
        end
    end

    // Fill index, fill bank pointer and committed vector lengths.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_fill_bank <= 1'b0;
            r_wr_idx    <= '0;
            r_len[0]    <= '0;
            r_len[1]    <= '0;
        end else if (w_accept) begin
            if (w_commit) begin
                r_wr_idx           <= '0;
                r_fill_bank        <= ~r_fill_bank;
                r_len[r_fill_bank] <= LEN_W'(r_wr_idx) + LEN_W'(1);
            end else begin
                r_wr_idx <= r_wr_idx + IDX_W'(1);
            end
        end
    end

    // Full flags: a commit and a release can land on the two banks in the same edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_full <= 2'b00;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (w_release && (r_rd_bank == 1'(b))) begin
                    r_full[b] <= 1'b0;
                end else if (w_commit && (r_fill_bank == 1'(b))) begin
                    r_full[b] <= 1'b1;
                end
            end
        end
    end

    // Sequencer state, stream/drain counters, read bank and active length.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_rd_idx    <= '0;
            r_drain_cnt <= '0;
            r_rd_bank   <= 1'b0;
            r_cur_len   <= '0;
        end else begin
            r_state     <= w_next_state;
            r_rd_idx    <= w_next_rd_idx;
            r_drain_cnt <= w_next_drain_cnt;
            if (w_release) begin
                r_rd_bank <= ~r_rd_bank;
            end
            if (w_start) begin
                r_cur_len <= r_len[r_rd_bank];
            end
        end
    end

    // Next-state logic; a finished vector chains straight into the next full bank.
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_next_state     = r_state;
        w_next_rd_idx    = r_rd_idx;
        w_next_drain_cnt = r_drain_cnt;
        w_release        = 1'b0;
        w_start          = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (r_full[r_rd_bank]) begin
                    w_next_state = S_CLEAR;
                    w_start      = 1'b1;
                end
            end
            S_CLEAR: begin
                w_next_state  = S_STREAM;
                w_next_rd_idx = '0;
            end
            S_STREAM: begin
                if (w_last_pair) begin
                    w_release        = 1'b1;
                    w_next_drain_cnt = '0;
                    w_next_state     = (PIPE_DEPTH == 0) ? S_DONE : S_DRAIN;
                end else begin
                    w_next_rd_idx = r_rd_idx + IDX_W'(1);
                end
            end
            S_DRAIN: begin
                if (r_drain_cnt == DRAIN_LAST) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_drain_cnt = r_drain_cnt + 2'd1;
                end
            end
            S_DONE: begin
                if (r_full[r_rd_bank]) begin
                    w_next_state = S_CLEAR;
                    w_start      = 1'b1;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Decode the MAC controls for the state being entered so they register in step with it.
    always_comb begin
        w_ce     = 1'b0;
        w_oload  = 1'b0;
        w_strobe = 1'b0;
        w_stream = 1'b0;
        unique case (w_next_state)
            S_CLEAR: begin
                w_ce    = 1'b1;
                w_oload = 1'b1;
            end
            S_STREAM: begin
                w_ce     = 1'b1;
                w_stream = 1'b1;
            end
            S_DRAIN: begin
                w_ce = 1'b1;
            end
            S_DONE: begin
                w_strobe = 1'b1;
            end
            default: begin
                w_ce = 1'b0;
            end
        endcase
    end

    // Registered MAC-facing outputs; operands are zero outside STREAM to flush the pipeline.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            MAC_A         <= '0;
            MAC_B         <= '0;
            MAC_CE        <= 1'b0;
            MAC_OLOAD     <= 1'b0;
            RESULT_STROBE <= 1'b0;
            RESULT_LEN    <= '0;
        end else begin
            MAC_CE        <= w_ce;
            MAC_OLOAD     <= w_oload;
            RESULT_STROBE <= w_strobe;
            MAC_A         <= w_stream ? w_rd_word[31:16] : 16'd0;
            MAC_B         <= w_stream ? w_rd_word[15:0]  : 16'd0;
            if (w_strobe) begin
                RESULT_LEN <= r_cur_len;
            end
        end
    end

endmodule

// File: tb/tb_mac_vector_feeder.sv
// Bench for mac_vector_feeder: two instances (PIPE_DEPTH 0 and 2), each with a
// queue-based expected-timeline model and a behavioural SB_MAC16 accumulator.
module tb_mac_vector_feeder;

    localparam int DEPTH = 16;
    localparam int LEN_W = 5;

    typedef struct packed {
        logic             ce;
        logic             oload;
        logic [15:0]      a;
        logic [15:0]      b;
        logic             strobe;
        logic [LEN_W-1:0] len;
        logic             rel;
        logic [31:0]      dot;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wr_valid [2];
    logic             wr_ready [2];
    logic             wr_last  [2];
    logic [15:0]      wr_a     [2];
    logic [15:0]      wr_b     [2];
    logic [15:0]      mac_a    [2];
    logic [15:0]      mac_b    [2];
    logic             mac_ce   [2];
    logic             mac_oload[2];
    logic             res_strobe[2];
    logic [LEN_W-1:0] res_len  [2];
    logic             busy     [2];

    // Expected-behaviour model state.
    exp_t        cur        [2];
    exp_t        script     [2][$];
    logic [31:0] bld        [2][$];
    logic [31:0] pend_pairs [2][$];
    int          pend_len   [2][$];
    int          unrel      [2];
    logic [31:0] acc        [2];
    logic [31:0] pipe       [2][4];
    logic [31:0] m_prod;
    logic [31:0] m_add;
    logic        m_ready;

    // Observed events for directed checks.
    int          oload_cyc [2][$];
    int          str_cyc   [2][$];
    int          str_len   [2][$];
    logic [31:0] str_acc   [2][$];
    int          acc_cyc   [2];

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    mac_vector_feeder #(.DEPTH(DEPTH), .LEN_W(LEN_W), .PIPE_DEPTH(0)) u_dut0 (
        .CLK(clk), .RST(rst),
        .WR_VALID(wr_valid[0]), .WR_READY(wr_ready[0]),
        .WR_A(wr_a[0]), .WR_B(wr_b[0]), .WR_LAST(wr_last[0]),
        .MAC_A(mac_a[0]), .MAC_B(mac_b[0]), .MAC_CE(mac_ce[0]), .MAC_OLOAD(mac_oload[0]),
        .RESULT_STROBE(res_strobe[0]), .RESULT_LEN(res_len[0]), .BUSY(busy[0])
    );

    mac_vector_feeder #(.DEPTH(DEPTH), .LEN_W(LEN_W), .PIPE_DEPTH(2)) u_dut2 (
        .CLK(clk), .RST(rst),
        .WR_VALID(wr_valid[1]), .WR_READY(wr_ready[1]),
        .WR_A(wr_a[1]), .WR_B(wr_b[1]), .WR_LAST(wr_last[1]),
        .MAC_A(mac_a[1]), .MAC_B(mac_b[1]), .MAC_CE(mac_ce[1]), .MAC_OLOAD(mac_oload[1]),
        .RESULT_STROBE(res_strobe[1]), .RESULT_LEN(res_len[1]), .BUSY(busy[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int pdepth(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expand the oldest waiting vector into its cycle-by-cycle output timeline.
    task automatic start_vector(input int d);
        int          len;
        logic [31:0] w;
        logic [31:0] dot;
        exp_t        e;
        len = pend_len[d].pop_front();
        dot = 32'd0;
        e = '0; e.ce = 1'b1; e.oload = 1'b1;
        script[d].push_back(e);
        for (int i = 0; i < len; i++) begin
            w = pend_pairs[d].pop_front();
            e = '0; e.ce = 1'b1; e.a = w[31:16]; e.b = w[15:0]; e.rel = (i == len - 1);
            dot = dot + 32'(w[31:16]) * 32'(w[15:0]);
            script[d].push_back(e);
        end
        for (int p = 0; p < pdepth(d); p++) begin
            e = '0; e.ce = 1'b1;
            script[d].push_back(e);
        end
        e = '0; e.strobe = 1'b1; e.len = LEN_W'(len); e.dot = dot;
        script[d].push_back(e);
    endtask

    // Model step per clock edge: external MAC, vector start, bank release, write capture.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                cur[d] = '0;
                script[d].delete();
                bld[d].delete();
                pend_pairs[d].delete();
                pend_len[d].delete();
                unrel[d] = 0;
                acc[d]   = 32'd0;
                for (int s = 0; s < 4; s++) pipe[d][s] = 32'd0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (mac_ce[d]) begin
                    m_prod = 32'(mac_a[d]) * 32'(mac_b[d]);
                    m_add  = (pdepth(d) == 0) ? m_prod : pipe[d][pdepth(d) - 1];
                    for (int s = 3; s > 0; s--) pipe[d][s] = pipe[d][s - 1];
                    pipe[d][0] = m_prod;
                    acc[d] = mac_oload[d] ? 32'd0 : acc[d] + m_add;
                end
                m_ready = (unrel[d] < 2);
                if (script[d].size() == 0 && !cur[d].ce && pend_len[d].size() > 0)
                    start_vector(d);
                if (cur[d].rel) unrel[d]--;
                if (wr_valid[d] && m_ready) begin
                    bld[d].push_back({wr_a[d], wr_b[d]});
                    if (wr_last[d] || bld[d].size() == DEPTH) begin
                        pend_len[d].push_back(bld[d].size());
                        for (int i = 0; i < bld[d].size(); i++) pend_pairs[d].push_back(bld[d][i]);
                        bld[d].delete();
                        unrel[d]++;
                    end
                end
                cur[d] = (script[d].size() > 0) ? script[d].pop_front() : exp_t'(0);
            end
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                string p;
                p = (d == 0) ? "p0" : "p2";
                check({p, "_ce"},     64'(mac_ce[d]),     64'(cur[d].ce));
                check({p, "_oload"},  64'(mac_oload[d]),  64'(cur[d].oload));
                check({p, "_a"},      64'(mac_a[d]),      64'(cur[d].a));
                check({p, "_b"},      64'(mac_b[d]),      64'(cur[d].b));
                check({p, "_strobe"}, 64'(res_strobe[d]), 64'(cur[d].strobe));
                check({p, "_busy"},   64'(busy[d]),       64'(cur[d].ce | cur[d].strobe));
                check({p, "_ready"},  64'(wr_ready[d]),   64'(unrel[d] < 2));
                if (cur[d].strobe) begin
                    check({p, "_len"}, 64'(res_len[d]), 64'(cur[d].len));
                    check({p, "_dot"}, 64'(acc[d]),     64'(cur[d].dot));
                end
                if (mac_oload[d]) oload_cyc[d].push_back(cyc);
                if (res_strobe[d]) begin
                    str_cyc[d].push_back(cyc);
                    str_len[d].push_back(int'(res_len[d]));
                    str_acc[d].push_back(acc[d]);
                end
            end
        end
    end

    // Offer one pair at a falling edge and hold it until accepted.
    task automatic put(input int d, input logic [15:0] a, input logic [15:0] b,
                       input logic last, output int waits);
        wr_valid[d] = 1'b1;
        wr_a[d]     = a;
        wr_b[d]     = b;
        wr_last[d]  = last;
        waits       = 0;
        while (!wr_ready[d] && waits < 300) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 300) check("wr_accept_timeout", 64'(0), 64'(1));
        acc_cyc[d] = cyc;
        @(negedge clk);
        wr_valid[d] = 1'b0;
        wr_last[d]  = 1'b0;
    endtask

    task automatic wait_strobes(input int d, input int n);
        int t;
        t = 0;
        while (str_cyc[d].size() < n && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("strobe_wait", 64'(str_cyc[d].size() >= n), 64'(1));
    endtask

    task automatic send_random(input int d, input int len, input int gap_max);
        int  w;
        logic last;
        logic force_commit;
        force_commit = (len == DEPTH) && ($urandom_range(0, 1) == 1);
        for (int i = 0; i < len; i++) begin
            repeat ($urandom_range(0, gap_max)) @(negedge clk);
            last = (i == len - 1) && !force_commit;
            put(d, 16'($urandom), 16'($urandom), last, w);
        end
    endtask

    task automatic check_reset_outputs(input int d);
        check("rst_ce",     64'(mac_ce[d]),     64'(0));
        check("rst_oload",  64'(mac_oload[d]),  64'(0));
        check("rst_a",      64'(mac_a[d]),      64'(0));
        check("rst_b",      64'(mac_b[d]),      64'(0));
        check("rst_strobe", 64'(res_strobe[d]), 64'(0));
        check("rst_len",    64'(res_len[d]),    64'(0));
        check("rst_busy",   64'(busy[d]),       64'(0));
        check("rst_ready",  64'(wr_ready[d]),   64'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int w;
        int wsum;
        int n0;
        int t;
        int base;
        for (int d = 0; d < 2; d++) begin
            wr_valid[d] = 1'b0;
            wr_last[d]  = 1'b0;
            wr_a[d]     = 16'd0;
            wr_b[d]     = 16'd0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs(0);
        check_reset_outputs(1);
        rst = 1'b0;
        @(negedge clk);

        // Three-pair vector, no pipeline: timing and dot product 44.
        put(0, 16'd1, 16'd2, 1'b0, w);
        put(0, 16'd3, 16'd4, 1'b0, w);
        put(0, 16'd5, 16'd6, 1'b1, w);
        c = acc_cyc[0];
        wait_strobes(0, 1);
        check("t1_clear_cycle",  64'(oload_cyc[0][0]), 64'(c + 2));
        check("t1_strobe_cycle", 64'(str_cyc[0][0]),   64'(c + 6));
        check("t1_len",          64'(str_len[0][0]),   64'(3));
        check("t1_dot",          64'(str_acc[0][0]),   64'(44));

        // Ping-pong: two vectors written without a gap.
        wsum = 0;
        put(0, 16'd2, 16'd3, 1'b0, w); wsum += w;
        put(0, 16'd2, 16'd3, 1'b1, w); wsum += w;
        put(0, 16'd7, 16'd7, 1'b1, w); wsum += w;
        check("t2_no_backpressure", 64'(wsum), 64'(0));
        wait_strobes(0, 3);
        check("t2_len_a", 64'(str_len[0][1]), 64'(2));
        check("t2_dot_a", 64'(str_acc[0][1]), 64'(12));
        check("t2_len_b", 64'(str_len[0][2]), 64'(1));
        check("t2_dot_b", 64'(str_acc[0][2]), 64'(49));
        check("t2_chained_clear", 64'(oload_cyc[0][2]), 64'(str_cyc[0][1] + 1));

        // Forced commit at DEPTH pairs, no LAST.
        for (int i = 0; i < DEPTH; i++) put(0, 16'd1, 16'd1, 1'b0, w);
        wait_strobes(0, 4);
        check("t3_len", 64'(str_len[0][3]), 64'(16));
        check("t3_dot", 64'(str_acc[0][3]), 64'(16));

        // Backpressure: second full vector written while the first streams.
        for (int i = 0; i < DEPTH; i++) put(0, 16'($urandom), 16'($urandom), 1'b0, w);
        c = acc_cyc[0];
        wsum = 0;
        for (int i = 0; i < DEPTH; i++) begin
            put(0, 16'($urandom), 16'($urandom), 1'b0, w);
            wsum += w;
        end
        check("t4_second_no_wait", 64'(wsum), 64'(0));
        check("t4_ready_low", 64'(wr_ready[0]), 64'(0));
        t = 0;
        while (!wr_ready[0] && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("t4_ready_return_cycle", 64'(cyc), 64'(c + 19));
        wait_strobes(0, 6);
        check("t4_len_a", 64'(str_len[0][4]), 64'(16));
        check("t4_len_b", 64'(str_len[0][5]), 64'(16));

        // Two-stage pipeline: drain cycles and full-scale product.
        put(1, 16'hFFFF, 16'hFFFF, 1'b0, w);
        put(1, 16'd1, 16'd1, 1'b1, w);
        c = acc_cyc[1];
        wait_strobes(1, 1);
        check("t5_clear_cycle",  64'(oload_cyc[1][0]), 64'(c + 2));
        check("t5_strobe_cycle", 64'(str_cyc[1][0]),   64'(c + 7));
        check("t5_len",          64'(str_len[1][0]),   64'(2));
        check("t5_dot",          64'(str_acc[1][0]),   64'h0000_0000_FFFE_0002);

        // Reset in the middle of a 10-pair stream.
        n0 = str_cyc[0].size();
        base = oload_cyc[0].size();
        for (int i = 0; i < 10; i++) put(0, 16'(i + 1), 16'd2, (i == 9), w);
        t = 0;
        while (oload_cyc[0].size() <= base && t < 50) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs(0);
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (20) @(negedge clk);
        check("t6_no_strobe", 64'(str_cyc[0].size()), 64'(n0));
        put(0, 16'd3, 16'd5, 1'b1, w);
        wait_strobes(0, n0 + 1);
        check("t6_len", 64'(str_len[0][n0]), 64'(1));
        check("t6_dot", 64'(str_acc[0][n0]), 64'(15));

        // Randomized vectors on both instances, checked cycle by cycle.
        for (int d = 0; d < 2; d++) begin
            base = str_cyc[d].size();
            for (int v = 0; v < 12; v++) begin
                send_random(d, $urandom_range(1, DEPTH), (v % 3 == 0) ? 0 : 2);
            end
            wait_strobes(d, base + 12);
        end

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mac_vector_feeder.md
Name: mac_vector_feeder

Overview:
- Double-buffered (ping-pong) operand feeder that sits directly upstream of the SB_MAC16 DSP slice when that slice is configured as an unsigned 16x16 multiply-accumulate.
- A producer writes vectors of (A,B) operand pairs into one bank while the other bank streams to the MAC one pair per cycle.
- The block sequences the MAC's clear, accumulate, pipeline-drain and result-valid phases, so the accumulated dot product appears on the MAC's O output when RESULT_STROBE pulses.

Parameters:
- DEPTH, 16, pairs per bank (power of two, 2..64); maximum vector length.
- LEN_W, 5, width of the length fields; must satisfy 2**LEN_W > DEPTH.
- PIPE_DEPTH, 0, number of enabled MAC pipeline register stages between operand input and accumulator (0..3); sets the drain length.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- WR_VALID  in  1  producer has a pair.
- WR_READY  out  1  fill bank can accept a pair.
- WR_A  in  16  operand A.
- WR_B  in  16  operand B.
- WR_LAST  in  1  this pair ends the vector.
- MAC_A  out  16  to the MAC A input; registered.
- MAC_B  out  16  to the MAC B input; registered.
- MAC_CE  out  1  to the MAC CE input; registered.
- MAC_OLOAD  out  1  to OLOADTOP/OLOADBOT, with the MAC C/D inputs tied to 0; registered.
- RESULT_STROBE  out  1  one-cycle pulse: MAC O holds the completed dot product; registered.
- RESULT_LEN  out  LEN_W  length of the vector just completed; valid with RESULT_STROBE.
- BUSY  out  1  FSM not in IDLE.

Behaviour:
- Reset (asynchronous):
  - Both banks empty; write pointer at bank 0, index 0; read bank 0; FSM IDLE.
  - WR_READY=1; MAC_A=MAC_B=0; MAC_CE=0; MAC_OLOAD=0; RESULT_STROBE=0; RESULT_LEN=0; BUSY=0.
- Write side:
  - A pair is accepted on a clock edge where WR_VALID and WR_READY are both 1. It is stored at fill_bank[idx] and idx increments.
  - The bank is committed (marked full, length=idx+1) when the accepted pair has WR_LAST=1, or when idx=DEPTH-1 (a forced commit with no LAST required).
  - On commit: idx returns to 0 and the fill pointer toggles to the other bank.
  - WR_READY = the fill-pointed bank is not full. With both banks full, WR_READY=0.
- Read side: each bank has a full flag. Banks are consumed strictly in commit order.
- FSM, with output values registered and shown as seen in the named state:
  - IDLE: CE=0, OLOAD=0, operands 0. Move to CLEAR when the read bank is full.
  - CLEAR (1 cycle): CE=1, OLOAD=1, operands 0. This zeroes the accumulator.
  - STREAM (len cycles): CE=1, OLOAD=0, MAC_A/MAC_B = bank[i] for i=0..len-1.
    - The bank's full flag clears on the edge ending the last STREAM cycle.
    - The read pointer toggles on that same edge.
  - DRAIN (PIPE_DEPTH cycles, skipped if 0): CE=1, OLOAD=0, operands 0. Zero products flush the pipeline.
  - DONE (1 cycle): CE=0, RESULT_STROBE=1, RESULT_LEN=len. Then IDLE.
  - BUSY is 1 in every state except IDLE.
- Latency: WR_LAST accepted in cycle c with the FSM idle →
  - CLEAR visible in cycle c+2;
  - STREAM in c+3..c+2+len;
  - RESULT_STROBE in c+3+len+PIPE_DEPTH.
- Back-to-back vectors: a second full bank starts CLEAR in the cycle after DONE.
- Refill during DRAIN/DONE: allowed, because the bank was released at the end of STREAM.
- Simultaneous commit on one bank and release of the other in the same edge: both take effect, with no lost state.
- MAC_CE=0 outside CLEAR/STREAM/DRAIN, so the MAC accumulator holds its result until the next CLEAR.
- Reset mid-operation: the vector is abandoned, with no RESULT_STROBE; all state returns to reset values immediately.

Test Plan:
- PIPE_DEPTH=0: write (1,2),(3,4),(5,6), LAST on the third, LAST accepted in cycle c → OLOAD=1 in c+2; operands 1/2, 3/4, 5/6 in c+3..c+5; RESULT_STROBE in c+6 with RESULT_LEN=3; behavioural MAC O=44.
- Ping-pong: vector (2,3)x2 immediately followed by vector (7,7), no idle → WR_READY stays 1 throughout; strobes report len 2 (O=12) and len 1 (O=49); the second CLEAR is in the cycle after the first DONE.
- Forced commit, DEPTH=16: 16 pairs of (1,1) with no LAST → bank commits; RESULT_LEN=16; O=16.
- Backpressure: hold RESULT path busy by writing two full 16-pair vectors while the first streams → WR_READY=0 after the second commit; it returns to 1 on the edge ending the first vector's last STREAM cycle.
- PIPE_DEPTH=2 with the MAC's REG1/REG2 enabled: (0xFFFF,0xFFFF),(1,1) → two DRAIN cycles with operands 0; O=0xFFFE0002 at RESULT_STROBE.
- Assert RST during the STREAM of a 10-pair vector → all outputs are at reset values in the same cycle; no strobe; WR_READY=1; a following 1-pair vector (3,5) gives O=15.
